dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder for the vector processor.
- Serves the processor's load/store word port: one 32-bit word per cycle, write enable, registered read data.
- Serves a DMA burst-read port on a second RAM port: a streaming valid/ready reader that takes a base/length command, e.g. the command the processor publishes through r15.
- Sits outside the processor, between the processor memory pins, the DMA/display consumer and the data RAM.

Parameters:
N, 32, word width in bits
DEPTH, 250000, number of words; valid word addresses are 0..DEPTH-1
LW, 8, width of the DMA length field

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-low reset
cpu_wen  input  1  write strobe from the processor
cpu_addr  input  N  word address from the processor
cpu_wdata  input  N  write data from the processor
cpu_rdata  output  N  read data to the processor, valid the cycle after the address
dma_req  input  1  burst command strobe
dma_base  input  N  burst start word address
dma_len  input  LW  burst length in words, 1..2^LW-1
dma_busy  output  1  burst in progress; commands are ignored while high
dma_valid  output  1  stream data valid
dma_ready  input  1  consumer ready
dma_rdata  output  N  stream data word
dma_done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (rst=0 at a clock edge): all outputs go to 0, FSM goes to IDLE, skid buffer is emptied. RAM contents are not cleared.
- Reset mid-burst: the burst is aborted silently, with no dma_done.
- CPU port (RAM port A), every cycle:
  - cpu_addr<DEPTH and cpu_wen=1: write cpu_wdata.
  - cpu_rdata<=RAM[cpu_addr], read-before-write, so a same-cycle write returns the old word.
  - cpu_addr>=DEPTH: the write is dropped and cpu_rdata<=0.
- DMA port (RAM port B), read-only.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: dma_req=1 and dma_len!=0 -> latch ptr=dma_base and remaining=dma_len; set dma_busy=1; go to RUN. dma_len=0 is ignored.
  - RUN: issue a read at ptr when the skid buffer will have space (credit = 2 - occupancy - reads in flight). On issue: ptr+1, remaining-1. When remaining reaches 0 -> DRAIN.
  - DRAIN: wait until the skid buffer is empty and nothing is in flight. Then pulse dma_done, clear dma_busy, go to IDLE.
- Read latency: read issued in cycle t -> data enters the skid buffer at t+1.
  - dma_valid=1 whenever the buffer is non-empty.
  - A word transfers when dma_valid and dma_ready are both 1.
  - Throughput is 1 word/cycle while dma_ready stays 1.
- Out-of-range words (ptr>=DEPTH, including ptr wrap past 2^N-1) are streamed as 0. The count still decrements.
- Stream ordering is strictly by ascending address. dma_rdata must be held stable while dma_valid=1 and dma_ready=0.
- dma_req while dma_busy=1 is ignored and not queued.
- Simultaneous CPU write and DMA read at the same address: the DMA sees the old word.

Optional Feature:
DMEM_ERR_FLAG_EN
- Defined: adds output err_oor, 1 bit, sticky. It is set when a CPU access or a DMA read uses an address >=DEPTH, and cleared only by reset.
- Undefined: port absent, no extra logic.

Decomposition:
- Package dmem_pkg:
  - dma_state_t enum {IDLE, RUN, DRAIN}
  - DMEM_DEPTH_DEFAULT = 250000
  - function in_range(addr)
- Sub-module dmem_skid_fifo: 2-entry valid/ready buffer, depth 2, with synchronous active-low reset, push/pop and an occupancy count.

Test Plan:
- Reset: hold rst=0 for 2 cycles with dma_req=1 -> dma_busy=0, dma_valid=0, dma_done=0, cpu_rdata=0.
- CPU write then read: write addr 5 = 0xDEADBEEF, then read 5 -> cpu_rdata=0xDEADBEEF one cycle later. Read addr 250000 -> 0, and the write to 250000 is dropped.
- Full-speed burst:
  - Preload addr 10..13 with 1,2,3,4.
  - Issue base=10, len=4 with dma_ready=1.
  - Expect 4 consecutive beats 1,2,3,4.
  - Expect dma_done pulsing exactly once, the cycle after the 4th beat.
- Backpressure: same burst with dma_ready toggling 1,0,0,1,... -> no word lost or duplicated, and dma_rdata stable while stalled.
- Edge cases:
  - base=249998, len=4 -> stream RAM[249998], RAM[249999], 0, 0.
  - dma_len=0 -> no busy.
  - dma_req during busy -> ignored.
- Reset mid-burst: after 2 of 8 beats, assert rst=0 -> idle next cycle, no dma_done. A new burst afterwards works normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
// Holds the DMA FSM state type, the default depth and the range check.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH_DEFAULT = 250000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } dma_state_t;

  function automatic logic in_range(
    input logic [31:0] addr,
    input int unsigned depth = DMEM_DEPTH_DEFAULT
  );
    return addr < depth;
  endfunction

endpackage

// File: rtl/dmem_skid_fifo.sv
// dmem_skid_fifo: 2-entry valid/ready buffer for the DMA stream.
// Ports: clk_i, rst_ni (sync, active-low), push_i/data_i in,
// pop_i in, valid_o/data_o head word, count_o occupancy (0..2).
module dmem_skid_fifo #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  // The issuer only pushes with a free slot; a push into
  // a full buffer without a pop is refused.
  assign push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);

  always_comb begin
    wr_d  = wr_q ^ push_ok;
    rd_d  = rd_q ^ pop_ok;
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_q] <= data_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data RAM with a CPU word port and a DMA burst reader.
// Ports: clk, rst (sync, active-low); cpu_wen/addr/wdata in, cpu_rdata
// out; dma_req/base/len in, dma_busy/valid/rdata/done out, dma_ready in;
// err_oor (sticky out-of-range flag) only with DMEM_ERR_FLAG_EN defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          N     = 32,
  parameter int unsigned DEPTH = DMEM_DEPTH_DEFAULT,
  parameter int          LW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_wen,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic [N-1:0]  cpu_rdata,
  input  logic          dma_req,
  input  logic [N-1:0]  dma_base,
  input  logic [LW-1:0] dma_len,
  output logic          dma_busy,
  output logic          dma_valid,
  input  logic          dma_ready,
  output logic [N-1:0]  dma_rdata,
  output logic          dma_done
`ifdef DMEM_ERR_FLAG_EN
  ,
  output logic          err_oor
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0] ram [DEPTH];

  dma_state_t    state_q, state_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          inflight_q;
  logic          cpu_ok, cpu_ok_q;
  logic          dma_ok, dma_ok_q;
  logic [N-1:0]  cpu_ram_q;
  logic [N-1:0]  dma_ram_q;
  logic [AW-1:0] cpu_idx;
  logic [AW-1:0] dma_idx;
  logic          issue;
  logic          done;
  logic          pop;
  logic [1:0]    occ;
  logic [2:0]    used;
  logic [2:0]    room;
  logic          credit_ok;

  assign cpu_ok  = in_range(32'(cpu_addr), DEPTH);
  assign dma_ok  = in_range(32'(ptr_q), DEPTH);
  assign cpu_idx = cpu_ok ? cpu_addr[AW-1:0] : '0;
  assign dma_idx = dma_ok ? ptr_q[AW-1:0] : '0;

  // Both ports read with non-blocking semantics, so a
  // same-cycle write is seen by neither read.
  always_ff @(posedge clk) begin
    if (cpu_wen && cpu_ok) ram[cpu_idx] <= cpu_wdata;
    cpu_ram_q <= ram[cpu_idx];
    dma_ram_q <= ram[dma_idx];
  end

  assign pop = dma_valid && dma_ready;

  // Counting this cycle's pop as free space keeps the
  // stream at one word per cycle under full readiness.
  always_comb begin
    used      = {1'b0, occ} + {2'b0, inflight_q};
    room      = 3'd1 + {2'b0, pop};
    credit_ok = (used <= room);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dma_req && (dma_len != '0)) begin
          ptr_d   = dma_base;
          rem_d   = dma_len;
          state_d = RUN;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          ptr_d = ptr_q + N'(1);
          rem_d = rem_q - LW'(1);
          if (rem_q == LW'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ == 2'd0) && !inflight_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      cpu_ok_q   <= 1'b0;
      dma_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      cpu_ok_q   <= cpu_ok;
      dma_ok_q   <= dma_ok;
    end
  end

  dmem_skid_fifo #(
    .W (N)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (inflight_q),
    .data_i  (dma_ok_q ? dma_ram_q : '0),
    .pop_i   (pop),
    .valid_o (dma_valid),
    .data_o  (dma_rdata),
    .count_o (occ)
  );

  assign cpu_rdata = cpu_ok_q ? cpu_ram_q : '0;
  assign dma_busy  = (state_q != IDLE);
  assign dma_done  = done;

`ifdef DMEM_ERR_FLAG_EN
  logic err_q, err_d;

  assign err_d = err_q || !cpu_ok || (issue && !dma_ok);

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err_oor = err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed + randomized bench for dmem_responder.
// Reference: sparse memory model and an expected-word queue per burst.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 250000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic [31:0] dma_base;
  logic [7:0]  dma_len;
  logic        dma_busy;
  logic        dma_valid;
  logic        dma_ready;
  logic [31:0] dma_rdata;
  logic        dma_done;
`ifdef DMEM_ERR_FLAG_EN
  logic        err_oor;
`endif

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_base  (dma_base),
    .dma_len   (dma_len),
    .dma_busy  (dma_busy),
    .dma_valid (dma_valid),
    .dma_ready (dma_ready),
    .dma_rdata (dma_rdata),
    .dma_done  (dma_done)
`ifdef DMEM_ERR_FLAG_EN
    ,
    .err_oor   (err_oor)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int beats = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit chk_en = 0;
  bit done_exp = 0;
  bit done_seen = 0;
  bit stall_prev = 0;
  logic [31:0] held = '0;
  logic [31:0] mem_m [int unsigned];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    if (a < DEPTH && mem_m.exists(a)) return mem_m[a];
    return 32'd0;
  endfunction

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        beat;
    logic        last;
    logic [31:0] cexp;
    beat = (dma_valid === 1'b1) && dma_ready;
    last = 1'b0;
    if (beat) begin
      check("beat_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("dma_rdata", dma_rdata, exp_q.pop_front());
        last = (exp_q.size() == 0);
      end
      if (beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      beats++;
    end
    if (chk_en) check("dma_done", dma_done, done_exp);
    if (dma_done === 1'b1) done_seen = 1;
    done_exp = last;
    if (stall_prev) begin
      check("hold_valid", dma_valid, 1);
      check("hold_data", dma_rdata, held);
    end
    stall_prev = (dma_valid === 1'b1) && !dma_ready;
    held = dma_rdata;
    cexp = !rst ? 32'd0 : ref_rd(cpu_addr);
    if (rst && cpu_wen && cpu_addr < DEPTH)
      mem_m[cpu_addr] = cpu_wdata;
    @(posedge clk);
    #1;
    cyc++;
    check("cpu_rdata", cpu_rdata, cexp);
    if (!rst) begin
      exp_q.delete();
      done_exp = 0;
      stall_prev = 0;
    end
  endtask

  task automatic cpu_write(logic [31:0] a, logic [31:0] d);
    cpu_wen = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    tick();
    cpu_wen = 1'b0;
  endtask

  task automatic start_burst(logic [31:0] b, logic [7:0] l,
                             logic rdy);
    dma_req = 1'b1;
    dma_base = b;
    dma_len = l;
    dma_ready = rdy;
    tick();
    dma_req = 1'b0;
    for (int i = 0; i < int'(l); i++)
      exp_q.push_back(ref_rd(b + 32'(i)));
    check("busy_set", dma_busy, 1);
    done_seen = 0;
    beats = 0;
  endtask

  // mode 0: ready high; 1: ready 1,0,0 repeating; 2: random
  task automatic run_burst(logic [31:0] b, logic [7:0] l,
                           int mode, bit spur);
    start_burst(b, l, mode != 1);
    for (int k = 0; k < 1000; k++) begin
      if (done_seen && exp_q.size() == 0) break;
      case (mode)
        0: dma_ready = 1'b1;
        1: dma_ready = (k % 3 == 0);
        default: dma_ready = 1'($urandom % 2);
      endcase
      if (spur && k == 1) begin
        dma_req = 1'b1;
        dma_base = b + 32'd100;
        dma_len = 8'd3;
      end
      tick();
      dma_req = 1'b0;
      if (spur && k == 1) check("busy_hold", dma_busy, 1);
    end
    check("burst_end",
          64'(done_seen && exp_q.size() == 0), 1);
    if (mode == 0)
      check("back_to_back", 64'(last_cyc - first_cyc),
            64'(int'(l) - 1));
    tick();
    check("busy_clr", dma_busy, 0);
  endtask

  initial begin
    logic [31:0] b;
    logic [7:0]  l;
    rst = 1'b0;
    cpu_wen = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    dma_req = 1'b1;
    dma_base = 32'd10;
    dma_len = 8'd4;
    dma_ready = 1'b0;

    tick();
    tick();
    check("rst_busy", dma_busy, 0);
    check("rst_valid", dma_valid, 0);
    check("rst_done", dma_done, 0);
    check("rst_cpu", cpu_rdata, 0);
`ifdef DMEM_ERR_FLAG_EN
    check("rst_err", err_oor, 0);
`endif
    rst = 1'b1;
    dma_req = 1'b0;
    chk_en = 1;
    tick();

    cpu_write(32'd5, 32'hDEADBEEF);
    cpu_addr = 32'd5;
    tick();
    check("cpu_rd5", cpu_rdata, 32'hDEADBEEF);
    cpu_write(DEPTH, 32'h12345678);
    cpu_addr = DEPTH;
    tick();
    check("cpu_oor", cpu_rdata, 0);
`ifdef DMEM_ERR_FLAG_EN
    check("err_set", err_oor, 1);
`endif
    cpu_addr = 32'd5;
    tick();
    check("cpu_rd5_again", cpu_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 4; i++)
      cpu_write(32'(10 + i), 32'(i + 1));
    run_burst(32'd10, 8'd4, 0, 0);
    run_burst(32'd10, 8'd4, 1, 0);

    cpu_write(DEPTH - 2, $urandom);
    cpu_write(DEPTH - 1, $urandom);
    run_burst(DEPTH - 2, 8'd4, 0, 0);

    dma_req = 1'b1;
    dma_base = 32'd10;
    dma_len = 8'd0;
    tick();
    dma_req = 1'b0;
    check("len0_busy", dma_busy, 0);
    tick();
    check("len0_valid", dma_valid, 0);

    for (int i = 20; i < 28; i++)
      cpu_write(32'(i), $urandom);
    run_burst(32'd20, 8'd8, 0, 1);

    start_burst(32'd20, 8'd8, 1'b1);
    for (int k = 0; k < 20 && beats < 2; k++) tick();
    check("mid_beats", 64'(beats), 2);
    rst = 1'b0;
    dma_ready = 1'b0;
    tick();
    check("mid_busy", dma_busy, 0);
    check("mid_valid", dma_valid, 0);
    check("mid_done", dma_done, 0);
    rst = 1'b1;
    dma_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    run_burst(32'd20, 8'd8, 0, 0);

    for (int r = 0; r < 6; r++) begin
      b = $urandom_range(1000, 200000);
      l = 8'($urandom_range(1, 40));
      for (int i = 0; i < int'(l); i++)
        cpu_write(b + 32'(i), $urandom);
      cpu_addr = b + 32'($urandom_range(0, int'(l) - 1));
      run_burst(b, l, 2, 0);
    end
    run_burst(32'hFFFF_FFF0, 8'd4, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
